// File: rtl/rx_clk_supervisor.sv
// Receive clock supervisor: sequences the DCM reset, waits for lock and gates the rx core.
// Optional lock-loss filter in RUN is enabled by defining RXCLK_LOCK_FILTER_EN.
module rx_clk_supervisor #(
    parameter int RST_PULSE     = 8,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3,
    parameter int DIV_RATIO     = 2,
    parameter int CNT_W         = 16,
    parameter int FILTER_LEN    = 4
) (
    input  logic       rxclk,
    input  logic       reset,
    input  logic       dcm_locked,
    input  logic       clear_fault,
    output logic       dcm_rst,
    output logic       core_rst,
    output logic       ce_div,
    output logic       lock_ok,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lost_count
);

    localparam int DIV_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;

    typedef enum logic [2:0] {
        S_DCM_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [3:0]         r_retry, w_retry_nxt;
    logic [7:0]         r_lost, w_lost_nxt;
    logic [DIV_W-1:0]   r_div, w_div_nxt;
    logic               r_sync1, r_locked_s;
    logic               r_dcm_rst, r_core_rst, r_ce_div, r_lock_ok, r_fault;
    logic               w_run_loss;

`ifdef RXCLK_LOCK_FILTER_EN
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    logic [FILT_W-1:0]  r_filt, w_filt_nxt;

    // Only a run of FILTER_LEN consecutive unlocked cycles counts as a loss.
    always_comb begin
        w_filt_nxt = '0;
        w_run_loss = 1'b0;
        if (r_state == S_RUN && !r_locked_s) begin
            if (r_filt == FILT_W'(FILTER_LEN - 1)) w_run_loss = 1'b1;
            else                                   w_filt_nxt = r_filt + FILT_W'(1);
        end
    end
`else
    always_comb w_run_loss = !r_locked_s;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        w_lost_nxt  = r_lost;
        case (r_state)
            S_DCM_RST: begin
                if (r_timer == CNT_W'(RST_PULSE - 1)) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_timer_nxt = '0;
                end else if (r_timer == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_timer_nxt = '0;
                    if (r_retry == 4'(MAX_RETRIES)) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt = S_DCM_RST;
                        w_retry_nxt = r_retry + 4'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            S_STABLE: begin
                // Lock loss takes priority over completing the stability window.
                if (!r_locked_s) begin
                    w_timer_nxt = '0;
                    if (r_retry == 4'(MAX_RETRIES)) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt = S_DCM_RST;
                        w_retry_nxt = r_retry + 4'd1;
                    end
                end else if (r_timer == CNT_W'(STABLE_CYCLES - 1)) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (w_run_loss) begin
                    w_state_nxt = S_DCM_RST;
                    w_timer_nxt = '0;
                    if (r_lost != 8'hFF) w_lost_nxt = r_lost + 8'd1;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    w_state_nxt = S_DCM_RST;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_DCM_RST;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Divider runs only while staying in RUN; ce_div is registered from its next value.
    always_comb begin
        w_div_nxt = '0;
        if (r_state == S_RUN && w_state_nxt == S_RUN && r_div != DIV_W'(DIV_RATIO - 1))
            w_div_nxt = r_div + DIV_W'(1);
    end

    always_ff @(posedge rxclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            r_state    <= S_DCM_RST;
            r_timer    <= '0;
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
            r_retry    <= '0;
            r_lost     <= '0;
            r_div      <= '0;
            r_dcm_rst  <= 1'b1;
            r_core_rst <= 1'b1;
            r_ce_div   <= 1'b0;
            r_lock_ok  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_sync1    <= dcm_locked;
            r_locked_s <= r_sync1;
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_retry    <= w_retry_nxt;
            r_lost     <= w_lost_nxt;
            r_div      <= w_div_nxt;
            r_dcm_rst  <= (w_state_nxt == S_DCM_RST);
            r_core_rst <= (w_state_nxt != S_RUN);
            r_ce_div   <= (w_state_nxt == S_RUN) && (w_div_nxt == DIV_W'(DIV_RATIO - 1));
            r_lock_ok  <= (w_state_nxt == S_RUN);
            r_fault    <= (w_state_nxt == S_FAULT);
        end
    end

`ifdef RXCLK_LOCK_FILTER_EN
    always_ff @(posedge rxclk) begin
        if (!reset) r_filt <= '0;
        else        r_filt <= w_filt_nxt;
    end
`endif

    assign dcm_rst     = r_dcm_rst;
    assign core_rst    = r_core_rst;
    assign ce_div      = r_ce_div;
    assign lock_ok     = r_lock_ok;
    assign fault       = r_fault;
    assign retry_count = r_retry;
    assign lost_count  = r_lost;

endmodule
